z80_bus_master: RTL

Z80_BUS_MASTER -- requirements
Module: z80_bus_master

---
 rtl/z80_bus_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/z80_bus_master.sv
// z80_bus_master: Z80-style T-state bus master for memory, I/O and M1 cycles
// Optional M1 refresh cycles are enabled by defining Z80BUS_RFSH_EN.
module z80_bus_master #(
   parameter int AW     = 16,
   parameter int MEM_WS = 0,
   parameter int IO_WS  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [2:0]    req_type,
   input  logic [AW-1:0] req_addr,
   input  logic [7:0]    req_wdata,
   output logic          rsp_valid,
   output logic [7:0]    rsp_rdata,
   output logic [AW-1:0] a,
   input  logic [7:0]    d_in,
   output logic [7:0]    d_out,
   output logic          d_oe,
   output logic          mreq_n,
   output logic          iorq_n,
   output logic          rd_n,
   output logic          wr_n,
   output logic          m1_n,
   output logic          rfsh_n,
   input  logic          wait_n,
   input  logic          busrq_n,
   output logic          busak_n
);
`ifdef Z80BUS_RFSH_EN
   localparam bit RFSH = 1'b1;
`else
   localparam bit RFSH = 1'b0;
`endif
   localparam logic [2:0] MRD = 3'd0, MWR = 3'd1, IORD = 3'd2, IOWR = 3'd3, M1 = 3'd4;
   typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4, BUSAK} state_t;
   state_t        state_q, state_d;
   logic [2:0]    typ_q, typ_d, cnt_q, cnt_d, ws;
   logic [AW-1:0] addr_q, addr_d, a_q, a_d;
   logic [7:0]    dat_q, dat_d, d_out_q, d_out_d, rdata_q, rdata_d;
   logic [6:0]    r_q, r_d;
   logic          rsp_q, rsp_d, ready_q, ready_d, d_oe_q, d_oe_d, busak_n_q, busak_n_d;
   logic          mreq_n_q, mreq_n_d, iorq_n_q, iorq_n_d, rd_n_q, rd_n_d;
   logic          wr_n_q, wr_n_d, m1_n_q, m1_n_d, rfsh_n_q, rfsh_n_d;
   logic          m1c, act, mid, ftch, rf;
   assign ws = (typ_q == IORD || typ_q == IOWR) ? 3'(IO_WS) : (typ_q == M1) ? 3'd0 : 3'(MEM_WS);
   // state register, latched request and registered bus outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         typ_q     <= MRD;
         addr_q    <= '0;
         cnt_q     <= 3'd0;
         dat_q     <= 8'h00;
         r_q       <= 7'd0;
         a_q       <= '0;
         d_out_q   <= 8'hFF;
         rdata_q   <= 8'hFF;
         rsp_q     <= 1'b0;
         ready_q   <= 1'b0;
         d_oe_q    <= 1'b0;
         busak_n_q <= 1'b1;
         mreq_n_q  <= 1'b1;
         iorq_n_q  <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         m1_n_q    <= 1'b1;
         rfsh_n_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         typ_q     <= typ_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         dat_q     <= dat_d;
         r_q       <= r_d;
         a_q       <= a_d;
         d_out_q   <= d_out_d;
         rdata_q   <= rdata_d;
         rsp_q     <= rsp_d;
         ready_q   <= ready_d;
         d_oe_q    <= d_oe_d;
         busak_n_q <= busak_n_d;
         mreq_n_q  <= mreq_n_d;
         iorq_n_q  <= iorq_n_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
         m1_n_q    <= m1_n_d;
         rfsh_n_q  <= rfsh_n_d;
      end
   end
   // next state: acceptance, forced/requested waits, completion and refresh counter
   always_comb begin
      state_d = state_q;
      typ_d   = typ_q;
      addr_d  = addr_q;
      d_out_d = d_out_q;
      cnt_d   = cnt_q;
      dat_d   = dat_q;
      r_d     = r_q;
      rsp_d   = 1'b0;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (!busrq_n) state_d = BUSAK;
            else if (req_valid && ready_q) begin
               state_d = T1;
               typ_d   = req_type;
               addr_d  = req_addr;
               d_out_d = req_wdata;
            end
         end
         T1: begin
            state_d = typ_q > M1 ? IDLE : T2;
            rsp_d   = typ_q > M1;
            rdata_d = typ_q > M1 ? 8'hFF : rdata_q;
         end
         T2: begin
            state_d = (ws != 3'd0 || !wait_n) ? TW : T3;
            cnt_d   = ws != 3'd0 ? ws - 3'd1 : 3'd0;
         end
         TW: begin
            state_d = (cnt_q != 3'd0 || !wait_n) ? TW : T3;
            cnt_d   = cnt_q != 3'd0 ? cnt_q - 3'd1 : 3'd0;
         end
         T3: begin
            state_d = typ_q == M1 ? T4 : IDLE;
            rsp_d   = typ_q != M1;
            rdata_d = typ_q == M1 ? rdata_q : (typ_q == MRD || typ_q == IORD) ? d_in : 8'hFF;
         end
         T4: begin
            state_d = IDLE;
            rsp_d   = 1'b1;
            rdata_d = dat_q;
            r_d     = r_q + 7'd1;
         end
         default: state_d = busrq_n ? IDLE : BUSAK;
      endcase
      if ((state_q == T2 || state_q == TW) && state_d == T3 && typ_q == M1) dat_d = d_in;
   end
   // bus outputs decoded from the state being entered so they are registered
   always_comb begin
      m1c       = typ_d == M1;
      act       = state_d == T1 || state_d == T2 || state_d == TW || state_d == T3;
      mid       = state_d == T2 || state_d == TW || state_d == T3;
      ftch      = m1c && (state_d == T1 || state_d == T2 || state_d == TW);
      rf        = RFSH && m1c && (state_d == T3 || state_d == T4);
      mreq_n_d  = !(((typ_d == MRD || typ_d == MWR) && act) || ftch || (rf && state_d == T3));
      rd_n_d    = !((typ_d == MRD && act) || (typ_d == IORD && mid) || ftch);
      wr_n_d    = !((typ_d == MWR || typ_d == IOWR) && mid);
      iorq_n_d  = !((typ_d == IORD || typ_d == IOWR) && mid);
      m1_n_d    = !ftch;
      rfsh_n_d  = !rf;
      d_oe_d    = (typ_d == MWR || typ_d == IOWR) && act;
      busak_n_d = state_d != BUSAK;
      ready_d   = state_d == IDLE && busrq_n;
      a_d       = state_d == BUSAK ? '0 : rf ? AW'(r_q) : addr_d;
   end
   assign req_ready = ready_q;
   assign rsp_valid = rsp_q;
   assign rsp_rdata = rdata_q;
   assign a         = a_q;
   assign d_out     = d_out_q;
   assign d_oe      = d_oe_q;
   assign mreq_n    = mreq_n_q;
   assign iorq_n    = iorq_n_q;
   assign rd_n      = rd_n_q;
   assign wr_n      = wr_n_q;
   assign m1_n      = m1_n_q;
   assign rfsh_n    = rfsh_n_q;
   assign busak_n   = busak_n_q;
endmodule
